// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, widths and defaults for the FIR load controller
// Purpose: the state encoding, word/output widths, default sequence lengths and
// sizing helpers that are common to fir_load_ctrl and fir_word_counter.
// Ports: none (package).
package fir_pkg;

  localparam int WORD_W         = 16;
  localparam int Y_W            = 32;
  localparam int OUT_CNT_W      = 8;
  localparam int NCOEF_DEF      = 64;
  localparam int NDATA_DEF      = 128;
  localparam int RUN_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_C = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..n; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_word_counter.sv
// rtl/fir_word_counter.sv - loadable up-counter with terminal-count flag
// Purpose: shared word/cycle counter for the coefficient, sample and run phases.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (count -> 0)
//   load_i     load load_val_i (takes priority over en_i)
//   load_val_i value to load
//   en_i       increment by one
//   term_i     terminal value compared against the current count
//   count_o    current count
//   tc_o       high while count_o equals term_i
module fir_word_counter
  import fir_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/fir_load_ctrl.sv
// rtl/fir_load_ctrl.sv - sequences coefficient load, sample load and run of a FIR filter
// Purpose: accepts a host word stream, presents NCOEF coefficients then NDATA
// samples to the filter, enables processing for RUN_CYCLES cycles and counts
// filter output strobes.
// Ports:
//   clk_10khz  clock, rising edge          rst       sync active-high reset
//   start      one-cycle sequence request  s_data    host word
//   s_valid    host word valid             s_ready   host word accepted
//   cload/cin  coefficient strobe/word     xload     sample phase indicator
//   xin/wr_en  sample word/strobe          rd_en     filter processing enable
//   y/valid    filter output/qualifier     busy      not idle
//   done       end-of-sequence pulse       out_count valid strobes seen in run
module fir_load_ctrl
  import fir_pkg::*;
#(
  parameter int NCOEF      = NCOEF_DEF,
  parameter int NDATA      = NDATA_DEF,
  parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
  input  logic                 clk_10khz,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 cload,
  output logic [WORD_W-1:0]    cin,
  output logic                 xload,
  output logic [WORD_W-1:0]    xin,
  output logic                 wr_en,
  output logic                 rd_en,
  input  logic [Y_W-1:0]       y,
  input  logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_CNT_W-1:0] out_count
);

  localparam int CW = cnt_width(max3(NCOEF, NDATA, RUN_CYCLES));
  localparam logic [CW-1:0] NCOEF_LAST = CW'(NCOEF - 1);
  localparam logic [CW-1:0] NDATA_LAST = CW'(NDATA - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);
  localparam logic [OUT_CNT_W-1:0] OUT_MAX = '1;

  state_e state_q, state_d;

  logic                 cload_q, cload_d;
  logic [WORD_W-1:0]    cin_q, cin_d;
  logic                 xload_q, xload_d;
  logic [WORD_W-1:0]    xin_q, xin_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 done_q, done_d;
  logic [OUT_CNT_W-1:0] out_count_q, out_count_d;

  logic          hs;
  logic          cnt_load;
  logic          cnt_en;
  logic [CW-1:0] cnt_term;
  logic          cnt_tc;
  logic [CW-1:0] unused_word_cnt;
  logic          unused_y;

  // y is only observed by the host, never by this block.
  assign unused_y = ^y;

  assign s_ready = (state_q == ST_LOAD_C) || (state_q == ST_LOAD_X);
  assign hs      = s_valid && s_ready;

  fir_word_counter #(
    .W (CW)
  ) u_word_counter (
    .clk_i      (clk_10khz),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .term_i     (cnt_term),
    .count_o    (unused_word_cnt),
    .tc_o       (cnt_tc)
  );

  // Next state and counter control. The counter is reloaded with 0 on every
  // phase change so each phase counts from zero against its own terminal value.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = NCOEF_LAST;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD_C;
          cnt_load = 1'b1;
        end
      end
      ST_LOAD_C: begin
        cnt_term = NCOEF_LAST;
        if (hs) begin
          if (cnt_tc) begin
            state_d  = ST_LOAD_X;
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_LOAD_X: begin
        cnt_term = NDATA_LAST;
        if (hs) begin
          if (cnt_tc) begin
            state_d  = ST_RUN;
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_term = RUN_LAST;
        if (cnt_tc) begin
          state_d  = ST_DONE;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered filter-side outputs.
  always_comb begin
    cload_d     = 1'b0;
    cin_d       = cin_q;
    wr_en_d     = 1'b0;
    xin_d       = xin_q;
    // High on entry into LOAD_X and for the cycle after the final sample.
    xload_d     = (state_q == ST_LOAD_X) || (state_d == ST_LOAD_X);
    // Registered from RUN: high from the second RUN cycle through the DONE
    // cycle, which is exactly RUN_CYCLES cycles.
    rd_en_d     = (state_q == ST_RUN);
    done_d      = (state_d == ST_DONE);
    out_count_d = out_count_q;

    if ((state_q == ST_LOAD_C) && hs) begin
      cload_d = 1'b1;
      cin_d   = s_data;
    end
    if ((state_q == ST_LOAD_X) && hs) begin
      wr_en_d = 1'b1;
      xin_d   = s_data;
    end

    if ((state_q == ST_IDLE) && start) begin
      out_count_d = '0;
    end else if (valid && rd_en_q && (out_count_q != OUT_MAX)) begin
      out_count_d = out_count_q + OUT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_10khz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cload_q     <= 1'b0;
      cin_q       <= '0;
      xload_q     <= 1'b0;
      xin_q       <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      done_q      <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cload_q     <= cload_d;
      cin_q       <= cin_d;
      xload_q     <= xload_d;
      xin_q       <= xin_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      done_q      <= done_d;
      out_count_q <= out_count_d;
    end
  end

  assign cload     = cload_q;
  assign cin       = cin_q;
  assign xload     = xload_q;
  assign xin       = xin_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign done      = done_q;
  assign out_count = out_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/fir_load_ctrl.md
FIR_LOAD_CTRL -- requirements
Module: fir_load_ctrl

Interface
REQ-001 Parameter NCOEF, default 64: number of coefficient words per load.
REQ-002 Parameter NDATA, default 128: number of sample words per load.
REQ-003 Parameter RUN_CYCLES, default 64: number of cycles rd_en is held high.
REQ-004 clk_10khz  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle request to begin a load/run sequence.
REQ-007 s_data  in  16  host word stream.
REQ-008 s_valid  in  1  s_data valid.
REQ-009 s_ready  out  1  block accepts s_data.
REQ-010 cload  out  1  coefficient-word qualifier to filter.
REQ-011 cin  out  16  coefficient word to filter.
REQ-012 xload  out  1  data-phase indicator to filter.
REQ-013 xin  out  16  sample word to filter.
REQ-014 wr_en  out  1  sample-word write strobe to filter.
REQ-015 rd_en  out  1  filter processing enable.
REQ-016 y  in  32  filter output, observed only.
REQ-017 valid  in  1  filter output qualifier.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 done  out  1  one-cycle pulse at sequence end.
REQ-020 out_count  out  8  number of valid pulses seen during RUN, saturating at 255.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD_C, LOAD_X, RUN and DONE.
REQ-022 In IDLE, start=1 SHALL move the FSM to LOAD_C and clear the word counter and out_count; start in any other state SHALL be ignored.
REQ-023 s_ready SHALL be high exactly in LOAD_C and LOAD_X (combinational from state).
REQ-024 A handshake (s_valid&&s_ready) in LOAD_C SHALL register cin<=s_data and cload<=1 for the following cycle; a cycle without a handshake SHALL give cload=0 and leave cin holding its value.
REQ-025 A handshake in LOAD_X SHALL register xin<=s_data and wr_en<=1 for the following cycle; a cycle without a handshake SHALL give wr_en=0.
REQ-026 xload SHALL be registered high from the first LOAD_X cycle through the cycle after the last data handshake.
REQ-027 The NCOEF-th handshake in LOAD_C SHALL move the FSM to LOAD_X on the same edge, and the word counter SHALL restart from 0.
REQ-028 The NDATA-th handshake in LOAD_X SHALL move the FSM to RUN on the same edge.
REQ-029 rd_en SHALL be high for exactly RUN_CYCLES consecutive cycles, starting the cycle after RUN is entered.
REQ-030 RUN SHALL then move to DONE.
REQ-031 Each cycle with valid=1 while rd_en=1 SHALL increment out_count, saturating at 255.
REQ-032 out_count SHALL hold its value until the next start.
REQ-033 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-034 Gaps in s_valid SHALL stall the counters; there is no timeout.
REQ-035 The word counter SHALL be wide enough for max(NCOEF, NDATA, RUN_CYCLES).

Reset
REQ-036 rst=1 SHALL force state=IDLE and all outputs and counters to 0 on the next edge, including mid-sequence; no partial-load state is retained.
REQ-037 rst SHALL take priority over start and over handshakes in the same cycle.

Structure
REQ-038 The shared package fir_pkg SHALL hold: the state enum, the NCOEF/NDATA/RUN_CYCLES defaults, the 16-bit word width and the 32-bit y width.
REQ-039 One sub-module, fir_word_counter, SHALL be used: a loadable up-counter with a terminal-count flag, shared by the load and run phases.

Verification
REQ-040 Reset, then start, then 64 back-to-back coefficients 0..63 -> cload high for 64 consecutive cycles, and cin follows each word one cycle after its handshake.
REQ-041 Continue with 128 samples 16'h1000+i sent with s_valid low every third cycle -> exactly 128 wr_en pulses with matching xin, and xload continuous.
REQ-042 Full sequence with valid driven high on 10 rd_en cycles -> rd_en high for exactly 64 cycles, done pulses once, out_count=10.
REQ-043 Assert rst on coefficient 30 -> next cycle state IDLE and all outputs 0; a new start reloads from coefficient 0.
REQ-044 start pulsed during LOAD_X and during RUN -> no effect on counters or state.
REQ-045 Hold valid=1 throughout RUN with RUN_CYCLES=300 -> out_count saturates at 255.
